// File: rtl/dmem_responder.sv
// Purpose: word-organized data-memory responder with byte masks and error responses.
// Latency: response strobe LATENCY edges after the accepting edge; one request per LATENCY+1 cycles.
// Backpressure: o_req_ready low while busy (requests then ignored); no response backpressure.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_ren/i_req_wen   read / write request (both set is an error)
//   i_req_addr            word-aligned byte address
//   i_req_wdata           write data in its byte lanes
//   i_req_mask            byte-lane enables
//   o_req_ready           request accepted on the next edge when high
//   o_res_valid           one-cycle response strobe
//   o_res_rdata           masked read data, zero otherwise
//   o_res_err             request rejected, qualified by o_res_valid
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_req_ready,
  output logic        o_res_valid,
  output logic [31:0] o_res_rdata,
  output logic        o_res_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          op_ren, op_wen;
  logic [31:0]   op_addr, op_wdata;
  logic [3:0]    op_mask;

  logic [31:0]   res_rdata;
  logic          res_err;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          access;
  logic [31:0]   word_idx;
  logic [AW-1:0] widx;
  logic          bad;
  logic [31:0]   lane_mask;

  assign o_req_ready = (state != BUSY);
  assign accept      = (i_req_ren | i_req_wen) & o_req_ready;
  assign access      = (state == BUSY) && (cnt == '0);

  // Unsigned 32-bit offset: an address below BASE_ADDR wraps to a huge
  // index, but it is also rejected explicitly so the check never relies on it.
  assign word_idx  = (op_addr - BASE_ADDR) >> 2;
  assign widx      = word_idx[AW-1:0];
  assign bad       = (op_ren & op_wen)
                   | (op_addr[1:0] != 2'b00)
                   | (op_mask == 4'b0000)
                   | (op_addr < BASE_ADDR)
                   | (word_idx >= DEPTH_WORDS);
  assign lane_mask = {{8{op_mask[3]}}, {8{op_mask[2]}}, {8{op_mask[1]}}, {8{op_mask[0]}}};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - CW'(1);
      end
      RESP: begin
        // A request may be taken in the response cycle itself.
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      res_rdata <= '0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // Response fields live for exactly the RESP cycle, zero elsewhere.
      res_rdata <= '0;
      res_err   <= 1'b0;
      if (access) begin
        res_err <= bad;
        if (!bad && op_ren) res_rdata <= mem[widx] & lane_mask;
      end
    end
  end

  // Request capture: datapath only, no reset needed.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_ren   <= i_req_ren;
      op_wen   <= i_req_wen;
      op_addr  <= i_req_addr;
      op_wdata <= i_req_wdata;
      op_mask  <= i_req_mask;
    end
  end

  // Array is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && access && !bad && op_wen && !op_ren) begin
      for (int b = 0; b < 4; b++) begin
        if (op_mask[b]) mem[widx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

  assign o_res_valid = (state == RESP);
  assign o_res_rdata = res_rdata;
  assign o_res_err   = res_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 64;

  // Instance 0: LATENCY 2, base 0. Instance 1: LATENCY 1, base 0x1000. Instance 2: LATENCY 5, base 0.
  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  logic        clk;
  logic        rst   [NI];
  logic        ren   [NI];
  logic        wen   [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  mask  [NI];
  logic        rdy   [NI];
  logic        vld   [NI];
  logic [31:0] rdata [NI];
  logic        err   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (lat_of(g)),
      .BASE_ADDR   (base_of(g))
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst[g]),
      .i_req_ren   (ren[g]),
      .i_req_wen   (wen[g]),
      .i_req_addr  (addr[g]),
      .i_req_wdata (wdata[g]),
      .i_req_mask  (mask[g]),
      .o_req_ready (rdy[g]),
      .o_res_valid (vld[g]),
      .o_res_rdata (rdata[g]),
      .o_res_err   (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          pend   [NI];
  int          due    [NI];
  bit          p_r    [NI];
  bit          p_w    [NI];
  logic [31:0] p_a    [NI];
  logic [31:0] p_d    [NI];
  logic [3:0]  p_m    [NI];
  int          resp_e [NI];
  logic [31:0] resp_d [NI];
  bit          resp_x [NI];
  logic [31:0] mm     [NI][DEPTH];

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  function automatic bit model_err(input int k, input bit r, input bit w,
                                   input logic [31:0] a, input logic [3:0] m);
    longint off;
    off = longint'(a) - longint'(base_of(k));
    return (r && w) || (a % 4 != 0) || (m == 4'h0) || (off < 0) || (off / 4 >= longint'(DEPTH));
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit e;
    int idx;
    cyc = cyc + 1;
    for (int k = 0; k < NI; k++) begin
      if (rst[k]) begin
        pend[k] = 1'b0;
      end else begin
        acc = !pend[k] && (ren[k] || wen[k]);
        if (pend[k] && cyc == due[k]) begin
          e         = model_err(k, p_r[k], p_w[k], p_a[k], p_m[k]);
          resp_e[k] = cyc;
          resp_x[k] = e;
          resp_d[k] = 32'h0;
          if (!e) begin
            idx = int'((longint'(p_a[k]) - longint'(base_of(k))) / 4);
            for (int b = 0; b < 4; b++) begin
              if (p_m[k][b]) begin
                if (p_w[k]) mm[k][idx][8*b +: 8] = p_d[k][8*b +: 8];
                else        resp_d[k][8*b +: 8]  = mm[k][idx][8*b +: 8];
              end
            end
          end
          pend[k] = 1'b0;
        end
        if (acc) begin
          pend[k] = 1'b1;
          due[k]  = cyc + lat_of(k);
          p_r[k]  = ren[k];
          p_w[k]  = wen[k];
          p_a[k]  = addr[k];
          p_d[k]  = wdata[k];
          p_m[k]  = mask[k];
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    logic [34:0] got;
    logic [34:0] exp;
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        got = {rdy[k], vld[k], err[k], rdata[k]};
        if (resp_e[k] == cyc) exp = {!pend[k], 1'b1, resp_x[k], resp_d[k]};
        else                  exp = {!pend[k], 1'b0, 1'b0, 32'h0};
        checks++;
        if (got !== exp) begin
          fails++;
          $display("FAIL cycle_check inst=%0d cyc=%0d: got rdy=%b vld=%b err=%b rdata=%h, required rdy=%b vld=%b err=%b rdata=%h",
                   k, cyc, got[34], got[33], got[32], got[31:0], exp[34], exp[33], exp[32], exp[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus helpers (entered and left just after a negedge) ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (pend[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pend[k]) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout inst=%0d: busy after %0d cycles, required idle", k, n);
    end
  endtask

  task automatic issue(input int k, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wait_ready(k);
    ren[k]   = r;
    wen[k]   = w;
    addr[k]  = a;
    wdata[k] = d;
    mask[k]  = m;
    @(negedge clk);
    ren[k] = 1'b0;
    wen[k] = 1'b0;
  endtask

  task automatic xact(input int k, input bit r, input bit w,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      output logic v, output logic [31:0] rd, output logic e);
    issue(k, r, w, a, d, m);
    repeat (lat_of(k)) @(negedge clk);
    v  = vld[k];
    rd = rdata[k];
    e  = err[k];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        v;
    logic        e;
    logic [31:0] d;
    logic [7:0]  rv;
    logic [7:0]  vv;
    int          vcnt;
    int          sel;
    logic [31:0] a;
    logic [3:0]  m;
    bit          r;
    bit          w;

    for (int k = 0; k < NI; k++) begin
      rst[k]    = 1'b1;
      ren[k]    = 1'b0;
      wen[k]    = 1'b0;
      addr[k]   = 32'h0;
      wdata[k]  = 32'h0;
      mask[k]   = 4'h0;
      resp_e[k] = -1;
      pend[k]   = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < NI; k++) begin
      check("reset_ready", rdy[k], 1);
      check("reset_valid", vld[k], 0);
      check("reset_rdata", rdata[k], 0);
      check("reset_err", err[k], 0);
    end

    // Give every word a known value.
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < DEPTH; i++)
        issue(k, 1'b0, 1'b1, base_of(k) + 32'(4 * i), $urandom, 4'hF);
    for (int k = 0; k < NI; k++) wait_ready(k);

    // Write then read, LATENCY 2.
    xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, v, d, e);
    check("wr_valid", v, 1);
    check("wr_err", e, 0);
    check("wr_rdata", d, 0);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, v, d, e);
    check("rd_valid", v, 1);
    check("rd_data", d, 32'hDEADBEEF);

    // Partial lanes.
    xact(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, v, d, e);
    xact(0, 1'b0, 1'b1, 32'h20, 32'hAA000000, 4'b1000, v, d, e);
    xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'b1100, v, d, e);
    check("partial_rdata", d, 32'hAA220000);

    // Error cases; word 0x10 holds 0xDEADBEEF throughout.
    xact(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF, v, d, e);
    check("err_both_valid", v, 1);
    check("err_both_err", e, 1);
    check("err_both_rdata", d, 0);
    xact(0, 1'b0, 1'b1, 32'h13, 32'h12345678, 4'hF, v, d, e);
    check("err_misalign_err", e, 1);
    check("err_misalign_rdata", d, 0);
    xact(0, 1'b0, 1'b1, 32'h10, 32'h12345678, 4'h0, v, d, e);
    check("err_mask0_err", e, 1);
    xact(0, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, v, d, e);
    check("err_range_rd_err", e, 1);
    check("err_range_rd_rdata", d, 0);
    xact(0, 1'b0, 1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, v, d, e);
    check("err_range_wr_err", e, 1);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, v, d, e);
    check("err_target_kept", d, 32'hDEADBEEF);
    xact(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, v, d, e);
    check("err_word0_kept", d, mm[0][0]);

    // Below base, BASE 0x1000, LATENCY 1.
    xact(1, 1'b0, 1'b1, 32'h0FFC, 32'hCAFEF00D, 4'hF, v, d, e);
    check("err_below_valid", v, 1);
    check("err_below_err", e, 1);
    check("err_below_rdata", d, 0);
    xact(1, 1'b1, 1'b0, 32'h1000 + 32'(4 * (DEPTH - 1)), 32'h0, 4'hF, v, d, e);
    check("err_below_lastword_kept", d, mm[1][DEPTH-1]);

    // Requests held continuously, LATENCY 1.
    wait_ready(1);
    ren[1]  = 1'b1;
    addr[1] = 32'h1000;
    mask[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rv[i] = rdy[1];
      vv[i] = vld[1];
    end
    ren[1] = 1'b0;
    check("b2b_ready_pattern", rv, 8'b10101010);
    check("b2b_valid_pattern", vv, 8'b10101010);

    // Request pulsed only while busy is ignored.
    xact(1, 1'b0, 1'b1, 32'h1008, 32'h01020304, 4'hF, v, d, e);
    issue(1, 1'b1, 1'b0, 32'h1004, 32'h0, 4'hF);
    check("busy_not_ready", rdy[1], 0);
    wen[1]   = 1'b1;
    addr[1]  = 32'h1008;
    wdata[1] = 32'h5A5A5A5A;
    @(negedge clk);
    wen[1] = 1'b0;
    vcnt = int'(vld[1]);
    repeat (5) begin
      @(negedge clk);
      vcnt += int'(vld[1]);
    end
    check("ignored_resp_count", vcnt, 1);
    xact(1, 1'b1, 1'b0, 32'h1008, 32'h0, 4'hF, v, d, e);
    check("ignored_no_write", d, 32'h01020304);

    // Reset mid-operation on both fast instances (instance 1: reset on the commit edge).
    for (int k = 0; k < 2; k++) begin
      xact(k, 1'b0, 1'b1, base_of(k) + 32'h40, 32'h0, 4'hF, v, d, e);
      issue(k, 1'b0, 1'b1, base_of(k) + 32'h40, 32'h55, 4'hF);
      rst[k] = 1'b1;
      @(negedge clk);
      rst[k] = 1'b0;
      check("midrst_ready", rdy[k], 1);
      check("midrst_valid", vld[k], 0);
      vcnt = 0;
      repeat (6) begin
        @(negedge clk);
        vcnt += int'(vld[k]);
      end
      check("midrst_no_resp", vcnt, 0);
      xact(k, 1'b1, 1'b0, base_of(k) + 32'h40, 32'h0, 4'hF, v, d, e);
      check("midrst_word_kept", d, 32'h0);
    end

    // Randomized traffic on all latencies.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 150; n++) begin
        sel = int'($urandom_range(0, 15));
        w   = bit'($urandom_range(0, 1));
        r   = !w;
        a   = base_of(k) + 32'(4 * $urandom_range(0, DEPTH - 1));
        m   = 4'($urandom);
        case (sel)
          0: begin r = 1'b1; w = 1'b1; end
          1: a = a + 32'($urandom_range(1, 3));
          2: a = base_of(k) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
          3: a = base_of(k) - 32'(4 * $urandom_range(1, 8));
          default: ;
        endcase
        issue(k, r, w, a, $urandom, m);
        if ($urandom_range(0, 5) == 0) begin
          ren[k]  = 1'b1;
          addr[k] = base_of(k) + 32'(4 * $urandom_range(0, DEPTH - 1));
          mask[k] = 4'hF;
          @(negedge clk);
          ren[k] = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_ready(k);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
